// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle control unit: state encoding, opcodes,
// datapath select encodings and ALU operation constants.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALU_WB,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_BRANCH,
    S_JAL,
    S_LUI,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  localparam logic [1:0] SRCA_PC     = 2'd0;
  localparam logic [1:0] SRCA_RS1    = 2'd1;
  localparam logic [1:0] SRCA_OLD_PC = 2'd2;
  localparam logic [1:0] SRCA_ZERO   = 2'd3;

  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_FOUR = 2'd2;

  localparam logic [1:0] RES_ALU     = 2'd0;
  localparam logic [1:0] RES_MEM     = 2'd1;
  localparam logic [1:0] RES_ALU_REG = 2'd2;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mc_mem_timer.sv
// Memory wait-state counter: counts unanswered request cycles and flags a bus
// timeout on the last permitted cycle unless ready arrives in that same cycle.
module mc_mem_timer
  import mc_pkg::*;
#(
  parameter int TIMEOUT_W   = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic req,
  input  logic ready,
  output logic expired
);

  logic [TIMEOUT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= '0;
    end else if (req && !ready) begin
      cnt <= cnt + TIMEOUT_W'(1);
    end
  end

  // cnt holds the number of wait cycles already spent, so this fires on the
  // MEM_TIMEOUT-th consecutive unanswered cycle.
  assign expired = req && !ready && (cnt == TIMEOUT_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RISC-V control unit with req/ready memory handshake, bus-timeout
// trap and retire counter. Define ILLEGAL_TRAP_EN to trap on unsupported opcodes.
module mc_ctrl_fsm
  import mc_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int TIMEOUT_W   = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            mem_req,
  output logic            write_mem,
  output logic            addr_src,
  output logic            ir_write,
  output logic            write_reg,
  output logic            pc_write,
  output logic [1:0]      alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [3:0]      alu_op,
  output logic [1:0]      result_src,
  output logic [2:0]      imm_type,
  output logic            trap,
  output logic [XLEN-1:0] instret
);

  state_t     state;
  state_t     next_state;
  logic       retire;
  logic       expired;
  logic       start;
  logic       branch_taken;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       unused_instr_bits;

  assign opcode            = instr[6:0];
  assign funct3            = instr[14:12];
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};
  assign branch_taken      = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);
  assign start             = is_mem_state(next_state) && (next_state != state);

  mc_mem_timer #(
    .TIMEOUT_W  (TIMEOUT_W),
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .req    (mem_req),
    .ready  (mem_ready),
    .expired(expired)
  );

  always_comb begin
    next_state = state;
    retire     = 1'b0;
    unique case (state)
      S_FETCH: begin
        if (mem_ready)    next_state = S_DECODE;
        else if (expired) next_state = S_TRAP;
      end
      S_DECODE: begin
        unique case (opcode)
          OP_R:               next_state = S_EXEC_R;
          OP_I:               next_state = S_EXEC_I;
          OP_LOAD, OP_STORE:  next_state = S_MEM_ADDR;
          OP_BRANCH:          next_state = S_BRANCH;
          OP_JAL:             next_state = S_JAL;
          OP_LUI:             next_state = S_LUI;
`ifdef ILLEGAL_TRAP_EN
          default:            next_state = S_TRAP;
`else
          default:            next_state = S_FETCH;
`endif
        endcase
      end
      S_EXEC_R, S_EXEC_I: next_state = S_ALU_WB;
      S_MEM_ADDR: next_state = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (mem_ready)    next_state = S_MEM_WB;
        else if (expired) next_state = S_TRAP;
      end
      S_MEM_WR: begin
        if (mem_ready) begin
          next_state = S_FETCH;
          retire     = 1'b1;
        end else if (expired) begin
          next_state = S_TRAP;
        end
      end
      S_ALU_WB, S_MEM_WB, S_BRANCH, S_JAL, S_LUI: begin
        next_state = S_FETCH;
        retire     = 1'b1;
      end
      S_TRAP:  next_state = S_TRAP;
      default: next_state = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_FETCH;
      instret <= '0;
    end else begin
      state <= next_state;
      if (retire) instret <= instret + XLEN'(1);
    end
  end

  // rst gates the decode so the bus request drops immediately, even though
  // the reset state (FETCH) would otherwise request memory.
  always_comb begin
    mem_req    = 1'b0;
    write_mem  = 1'b0;
    addr_src   = 1'b0;
    ir_write   = 1'b0;
    write_reg  = 1'b0;
    pc_write   = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALU_ADD;
    result_src = RES_ALU;
    imm_type   = IMM_I;
    trap       = 1'b0;
    if (!rst) begin
      unique case (state)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write  = 1'b1;
            pc_write  = 1'b1;
            alu_src_a = SRCA_PC;
            alu_src_b = SRCB_FOUR;
          end
        end
        S_DECODE: begin
          alu_src_a = SRCA_OLD_PC;
          alu_src_b = SRCB_IMM;
          imm_type  = IMM_B;
        end
        S_EXEC_R: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_RS2;
          alu_op    = {instr[30], funct3};
        end
        S_EXEC_I: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          imm_type  = IMM_I;
          alu_op    = {(funct3 == 3'b101) && instr[30], funct3};
        end
        S_ALU_WB: begin
          write_reg  = 1'b1;
          result_src = RES_ALU_REG;
        end
        S_MEM_ADDR: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          imm_type  = (opcode == OP_LOAD) ? IMM_I : IMM_S;
        end
        S_MEM_RD: begin
          mem_req  = 1'b1;
          addr_src = 1'b1;
        end
        S_MEM_WB: begin
          write_reg  = 1'b1;
          result_src = RES_MEM;
        end
        S_MEM_WR: begin
          mem_req   = 1'b1;
          write_mem = 1'b1;
          addr_src  = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_RS2;
          alu_op    = ALU_SUB;
          if (branch_taken) begin
            pc_write   = 1'b1;
            result_src = RES_ALU_REG;
          end
        end
        S_JAL: begin
          write_reg  = 1'b1;
          pc_write   = 1'b1;
          alu_src_a  = SRCA_OLD_PC;
          alu_src_b  = SRCB_FOUR;
          result_src = RES_ALU;
        end
        S_LUI: begin
          write_reg  = 1'b1;
          alu_src_a  = SRCA_ZERO;
          alu_src_b  = SRCB_IMM;
          imm_type   = IMM_U;
          result_src = RES_ALU;
        end
        S_TRAP:  trap = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
